datamem_dump_reader: RTL
========================

// Module: datamem_dump_reader
// PURPOSE
//  Read-side companion of the 16x8 data memory. On a start pulse it drives the
//  memory's read_select and walks a contiguous address window.
//  Each sampled word goes out on a valid/ready byte stream tagged with its
//  address, for the debug/display path.
//  The block never writes memory and runs concurrently with the CPU.
// PARAMETERS
//  DATA_W  8   memory word width
//  ADDR_W  4   memory address width; DEPTH = 2**ADDR_W = 16
// PORTS
//  clock        in   1       single clock, all state on rising edge
//  reset_n      in   1       asynchronous, active-low reset
//  start        in   1       1-cycle request; accepted only in IDLE
//  start_addr   in   ADDR_W  first address, latched at accept
//  count        in   ADDR_W  words to read, latched at accept; 0 means DEPTH (16)
//  abort        in   1       synchronous cancel of a dump
//  read_select  out  ADDR_W  to data memory read_select
//  mem_rdata    in   DATA_W  from data memory data_memory_output (combinational)
//  out_valid    out  1       stream beat valid
//  out_ready    in   1       sink ready
//  out_data     out  DATA_W  beat payload
//  out_addr     out  ADDR_W  address of payload
//  out_last     out  1       final beat of the dump
//  busy         out  1       high in any state except IDLE
//  done         out  1       1-cycle pulse when a dump completes (not on abort)
// BEHAVIOUR
//  - Reset (async, reset_n=0): state=IDLE. All outputs are 0.
//    Internal address, remaining count and sum are 0.
//  - FSM states: IDLE, FETCH, SEND, SUM (SUM only with macro), DONE.
//  - IDLE: read_select=addr_q. On start=1, latch addr_q<=start_addr and rem<=count.
//    Clear sum. Go to FETCH.
//  - FETCH (1 cycle, read_select=addr_q): register out_data<=mem_rdata and out_addr<=addr_q.
//    Set out_valid<=1. Set out_last<=(rem==1 && no checksum beat).
//    Update sum<=sum+mem_rdata (mod 256). Update addr_q<=addr_q+1 (wraps 15->0).
//    Update rem<=rem-1 (4-bit; latched 0 underflows to 15, giving 16 words). Go to SEND.
//  - SEND: hold out_data, out_addr and out_last stable while out_valid and not out_ready.
//    On out_valid&out_ready: clear out_valid.
//    If rem==0, go to SUM (macro) or DONE. Otherwise go to FETCH.
//  - DONE: done=1 for exactly one cycle, busy=1. Next state IDLE.
//  - Latency: start accepted at cycle N; first out_valid at N+2.
//    Sustained rate is 1 word per 2 cycles with out_ready=1.
//  - Data is sampled in the FETCH cycle. A CPU write to the same address in that
//    cycle yields the pre-write value. A dump is not an atomic snapshot.
//  - Address window wraps modulo DEPTH, e.g. start_addr=14, count=4 -> 14,15,0,1.
//  - start while busy: ignored, no latch.
//  - abort (any non-IDLE state, priority over all else): next cycle IDLE.
//    out_valid=0, out_last=0, no done pulse. A pending beat is dropped.
//  - Simultaneous start and abort in IDLE: start is ignored.
//  - reset_n low mid-dump: immediate return to reset values; no partial done.
// CONFIGURATION
//  DUMP_CHECKSUM_EN defined:
//    - After the last data beat, SUM state emits one extra beat:
//      out_data=sum mod 256, out_addr=0, out_last=1.
//    - That beat follows the same hold-until-ready rule, then DONE.
//    - The last data beat has out_last=0.
//  DUMP_CHECKSUM_EN undefined:
//    - No SUM state and no sum register.
//    - out_last marks the last data beat.
// TESTING
//  1. Memory preloaded mem[i]=i*3; start_addr=0, count=0, out_ready=1 ->
//     16 beats, addr 0..15, data 0x00..0x2D, out_last on addr 15, done 1 cycle later.
//  2. start_addr=14, count=4 -> beats at addr 14,15,0,1 (wrap); out_last on addr 1.
//  3. Sink stalls: out_ready=0 for 5 cycles on beat 2 ->
//     out_data/out_addr held constant, no extra beats, order preserved.
//  4. abort asserted in SEND of beat 3 -> next cycle IDLE, out_valid=0, busy=0,
//     no done; a new start then works.
//  5. reset_n pulsed low mid-dump -> all outputs 0 asynchronously; start is
//     re-accepted after release.
//  6. DUMP_CHECKSUM_EN, mem[i]=0x20 for i=0..15, count=0 ->
//     17th beat data=0x00 (512 mod 256), out_last=1.
//     Also count=2 at addr 0 with mem 0xFF,0x02 -> checksum beat 0x01.

Source files
------------

// File: rtl/datamem_dump_reader.sv
// datamem_dump_reader
// Read-side companion of the 16x8 data memory. On a start pulse it walks a
// contiguous (wrapping) address window through read_select and streams each
// sampled word out on a valid/ready byte stream, tagged with its address.
// Optional feature macro: DUMP_CHECKSUM_EN appends one checksum beat
// (sum of the dumped words mod 256, address 0, out_last=1) after the data.

module datamem_dump_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W-1:0] count,
  input  logic              abort,
  output logic [ADDR_W-1:0] read_select,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    SEND  = 3'd2,
`ifdef DUMP_CHECKSUM_EN
    SUM   = 3'd3,
`endif
    DONE  = 3'd4
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] rem_q;
  logic              handshake;
  logic              kill;
  logic              accept;

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;
`endif

  // A beat moves when both sides agree; abort only matters once a dump is running,
  // and a start that coincides with abort in IDLE is deliberately dropped.
  assign handshake   = out_valid && out_ready;
  assign kill        = (state_q != IDLE) && abort;
  assign accept      = (state_q == IDLE) && start && !abort;
  assign read_select = addr_q;
  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: abort wins over everything, otherwise fetch/send alternate until rem runs out.
  always_comb begin
    state_d = state_q;
    if (kill) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:  if (accept) state_d = FETCH;
        FETCH: state_d = SEND;
        SEND: begin
          if (handshake) begin
            if (rem_q == '0) begin
`ifdef DUMP_CHECKSUM_EN
              state_d = SUM;
`else
              state_d = DONE;
`endif
            end else begin
              state_d = FETCH;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        SUM:   if (handshake) state_d = DONE;
`endif
        DONE:  state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath: window bookkeeping, the registered beat and (optionally) the running sum.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr_q    <= '0;
      rem_q     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else if (kill) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            addr_q <= start_addr;
            rem_q  <= count;
`ifdef DUMP_CHECKSUM_EN
            sum_q  <= '0;
`endif
          end
        end
        FETCH: begin
          out_data  <= mem_rdata;
          out_addr  <= addr_q;
          out_valid <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
          out_last  <= 1'b0;
          sum_q     <= sum_q + mem_rdata;
`else
          out_last  <= (rem_q == ADDR_W'(1));
`endif
          addr_q    <= addr_q + ADDR_W'(1);
          rem_q     <= rem_q - ADDR_W'(1);
        end
        SEND: begin
          if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
            if (rem_q == '0) begin
              out_valid <= 1'b1;
              out_data  <= sum_q;
              out_addr  <= '0;
              out_last  <= 1'b1;
            end
`endif
          end
        end
`ifdef DUMP_CHECKSUM_EN
        SUM: begin
          if (handshake) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end
        end
`endif
        default: begin
        end
      endcase
    end
  end

endmodule
